// File: rtl/cpu_debug_ctrl_if.sv
// Host-side bundle for cpu_debug_ctrl: command channel plus scan beat stream.
// The host (UART/VIO bridge or testbench) uses the master modport; the
// controller uses the slave modport.
interface cpu_debug_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [2:0]        cmd_idx;
  logic [DATA_W-1:0] cmd_arg;
  logic              cmd_err;

  // Scan beat stream
  logic              scan_valid;
  logic              scan_ready;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic              scan_last;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_arg, scan_ready,
    input  cmd_ready, cmd_err, scan_valid, scan_addr, scan_data, scan_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_arg, scan_ready,
    output cmd_ready, cmd_err, scan_valid, scan_addr, scan_data, scan_last
  );
endinterface

// File: rtl/cpu_debug_ctrl.sv
// Run/halt/step controller and register-scan sequencer for the Cpu debug port.
// Accepts host commands, gates the Cpu clock enable, stops on PC breakpoints,
// bounds single steps with a timeout, and streams debug registers out as
// handshaked beats (one beat per three cycles at full rate).
module cpu_debug_ctrl #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int SCAN_FIRST   = 0,
  parameter int SCAN_LAST    = 127,
  parameter int NUM_BP       = 2,
  parameter int STEP_TIMEOUT = 64
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  cpu_debug_ctrl_if.slave   host,
  input  logic [DATA_W-1:0] cpu_pc_i,
  input  logic              cpu_retire_i,
  output logic              cpu_en_o,
  output logic              debug_en_o,
  output logic [ADDR_W-1:0] debug_addr_o,
  input  logic [DATA_W-1:0] debug_data_i,
  output logic              halted_o,
  output logic [NUM_BP-1:0] bp_hit_o,
  output logic              step_err_o
);

  localparam int                CNT_W    = $clog2(STEP_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(SCAN_FIRST);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(SCAN_LAST);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(STEP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_HALT, ST_RUN, ST_STEP, ST_SCAN_ADDR, ST_SCAN_CAP, ST_SCAN_OUT
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP, OP_RUN, OP_HALT, OP_STEP, OP_SCAN, OP_SET_BP, OP_CLR_BP, OP_RSVD
  } op_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] debug_addr_q, debug_addr_d;
  logic              scan_valid_q, scan_valid_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic [DATA_W-1:0] scan_data_q, scan_data_d;
  logic              scan_last_q, scan_last_d;
  logic              cmd_err_q, cmd_err_d;
  logic [NUM_BP-1:0] bp_hit_q, bp_hit_d;
  logic              step_err_q, step_err_d;
  logic [NUM_BP-1:0] bp_en_q, bp_en_d;
  logic [NUM_BP-1:0] bp_pc_we;
  logic [DATA_W-1:0] bp_pc_q [NUM_BP];

  op_e               op;
  logic              cmd_ready;
  logic              cmd_fire;
  logic              idx_ok;
  logic [NUM_BP-1:0] bp_match;

  assign op        = op_e'(host.cmd_op);
  assign cmd_ready = (state_q == ST_HALT) || (state_q == ST_RUN);
  assign cmd_fire  = host.cmd_valid && cmd_ready;
  assign idx_ok    = {29'd0, host.cmd_idx} < 32'(NUM_BP);

  // Breakpoint comparators: a hit needs an enabled entry and a retiring PC match.
  always_comb begin
    for (int i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_en_q[i] && cpu_retire_i && (cpu_pc_i == bp_pc_q[i]);
    end
  end

  // Next-state and register-update logic for the whole controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    debug_addr_d = debug_addr_q;
    scan_valid_d = scan_valid_q;
    scan_addr_d  = scan_addr_q;
    scan_data_d  = scan_data_q;
    scan_last_d  = scan_last_q;
    cmd_err_d    = 1'b0;
    bp_hit_d     = bp_hit_q;
    step_err_d   = step_err_q;
    bp_en_d      = bp_en_q;
    bp_pc_we     = '0;

    // Breakpoint table writes are legal whenever a command is accepted.
    if (cmd_fire && (op == OP_SET_BP || op == OP_CLR_BP)) begin
      if (idx_ok) begin
        for (int i = 0; i < NUM_BP; i++) begin
          if (host.cmd_idx == 3'(i)) begin
            bp_en_d[i]  = (op == OP_SET_BP);
            bp_pc_we[i] = (op == OP_SET_BP);
          end
        end
      end else begin
        cmd_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_HALT: begin
        if (cmd_fire) begin
          case (op)
            OP_RUN: begin
              state_d    = ST_RUN;
              bp_hit_d   = '0;
              step_err_d = 1'b0;
            end
            OP_STEP: begin
              state_d    = ST_STEP;
              cnt_d      = '0;
              bp_hit_d   = '0;
              step_err_d = 1'b0;
            end
            OP_SCAN: state_d   = ST_SCAN_ADDR;
            OP_RSVD: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        // A breakpoint and a HALT command in the same cycle both land in HALT once.
        if (|bp_match) begin
          bp_hit_d = bp_match;
          state_d  = ST_HALT;
        end
        if (cmd_fire) begin
          case (op)
            OP_HALT: state_d = ST_HALT;
            OP_RUN, OP_STEP, OP_SCAN, OP_RSVD: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end

      ST_STEP: begin
        // Breakpoints are deliberately ignored while stepping.
        if (cpu_retire_i) begin
          state_d = ST_HALT;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = ST_HALT;
          step_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SCAN_ADDR: state_d = ST_SCAN_CAP;

      ST_SCAN_CAP: begin
        // debug_addr has been stable for a cycle, so debug_data is valid now.
        scan_valid_d = 1'b1;
        scan_addr_d  = debug_addr_q;
        scan_data_d  = debug_data_i;
        scan_last_d  = (debug_addr_q == LAST_A);
        state_d      = ST_SCAN_OUT;
      end

      ST_SCAN_OUT: begin
        if (host.scan_ready) begin
          scan_valid_d = 1'b0;
          scan_last_d  = 1'b0;
          if (debug_addr_q == LAST_A) begin
            debug_addr_d = FIRST_A;
            state_d      = ST_HALT;
          end else begin
            debug_addr_d = debug_addr_q + ADDR_W'(1);
            state_d      = ST_SCAN_ADDR;
          end
        end
      end

      default: state_d = ST_HALT;
    endcase
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_ni) begin
      state_q      <= ST_HALT;
      cnt_q        <= '0;
      debug_addr_q <= FIRST_A;
      scan_valid_q <= 1'b0;
      scan_addr_q  <= '0;
      scan_data_q  <= '0;
      scan_last_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      bp_hit_q     <= '0;
      step_err_q   <= 1'b0;
      bp_en_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      debug_addr_q <= debug_addr_d;
      scan_valid_q <= scan_valid_d;
      scan_addr_q  <= scan_addr_d;
      scan_data_q  <= scan_data_d;
      scan_last_q  <= scan_last_d;
      cmd_err_q    <= cmd_err_d;
      bp_hit_q     <= bp_hit_d;
      step_err_q   <= step_err_d;
      bp_en_q      <= bp_en_d;
    end
  end

  // Breakpoint PC storage, written on SET_BP.
  always_ff @(posedge clock_i) begin
    // NOTE: PC entries are not reset; each is qualified by its enable bit, which is.
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_pc_we[i]) bp_pc_q[i] <= host.cmd_arg;
    end
  end

  assign cpu_en_o        = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign debug_en_o      = (state_q == ST_SCAN_ADDR) || (state_q == ST_SCAN_CAP) ||
                           (state_q == ST_SCAN_OUT);
  assign debug_addr_o    = debug_addr_q;
  assign halted_o        = (state_q == ST_HALT);
  assign bp_hit_o        = bp_hit_q;
  assign step_err_o      = step_err_q;
  assign host.cmd_ready  = cmd_ready;
  assign host.cmd_err    = cmd_err_q;
  assign host.scan_valid = scan_valid_q;
  assign host.scan_addr  = scan_addr_q;
  assign host.scan_data  = scan_data_q;
  assign host.scan_last  = scan_last_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed testbench for cpu_debug_ctrl. Scan beats and command-error pulses
// are checked by monitors against scoreboard queues filled by the stimulus;
// run/halt/step status is checked directly after each directed vector.
module tb_cpu_debug_ctrl;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int NUM_BP = 2;

  localparam logic [2:0] OP_NOP = 3'd0, OP_RUN = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3;
  localparam logic [2:0] OP_SCAN = 3'd4, OP_SET = 3'd5, OP_CLR = 3'd6, OP_RSVD = 3'd7;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] cpu_pc;
  logic              cpu_retire;
  logic              cpu_en;
  logic              debug_en;
  logic [ADDR_W-1:0] debug_addr;
  logic [DATA_W-1:0] debug_data = '0;
  logic              halted;
  logic [NUM_BP-1:0] bp_hit;
  logic              step_err;

  int    vec_cnt  = 0;
  int    miss_cnt = 0;
  int    cyc      = 0;
  int    en_cnt   = 0;
  int    t0;
  bit    hs_prev  = 1'b0;
  beat_t scan_q[$];
  int    err_q[$];

  cpu_debug_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();

  cpu_debug_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCAN_FIRST(0), .SCAN_LAST(3),
    .NUM_BP(NUM_BP), .STEP_TIMEOUT(64)
  ) dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .host         (host),
    .cpu_pc_i     (cpu_pc),
    .cpu_retire_i (cpu_retire),
    .cpu_en_o     (cpu_en),
    .debug_en_o   (debug_en),
    .debug_addr_o (debug_addr),
    .debug_data_i (debug_data),
    .halted_o     (halted),
    .bp_hit_o     (bp_hit),
    .step_err_o   (step_err)
  );

  always #5 clk = ~clk;

  // Cycle counter and a Cpu debug register file with one cycle of read latency.
  always @(posedge clk) begin
    cyc++;
    debug_data <= 32'(debug_addr) * 32'h11;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [2:0] idx,
                          input logic [31:0] arg, input bit exp_err);
    int n = 0;
    host.cmd_valid = 1'b1;
    host.cmd_op    = op;
    host.cmd_idx   = idx;
    host.cmd_arg   = arg;
    while (!host.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("cmd_ready", 32'(host.cmd_ready), 32'd1);
    if (exp_err) err_q.push_back(cyc + 1);
    tick();
    host.cmd_valid = 1'b0;
    host.cmd_op    = OP_NOP;
  endtask

  task automatic retire(input logic [31:0] pc);
    cpu_pc     = pc;
    cpu_retire = 1'b1;
    tick();
    cpu_retire = 1'b0;
  endtask

  task automatic push_scan();
    for (int a = 0; a < 4; a++) begin
      beat_t b;
      b.addr = ADDR_W'(a);
      b.data = 32'(a) * 32'h11;
      b.last = (a == 3);
      scan_q.push_back(b);
    end
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(halted), 32'd1);
  endtask

  // Scan monitor: every presented beat must equal the scoreboard head and stay
  // stable until consumed; valid must drop right after a handshake.
  always @(negedge clk) begin
    if (hs_prev) check("scan_valid_drop", 32'(host.scan_valid), 32'd0);
    hs_prev = host.scan_valid && host.scan_ready;
    if (host.scan_valid === 1'b1) begin
      if (scan_q.size() == 0) begin
        check("scan_unexpected", 32'(host.scan_addr), 32'hFFFF_FFFF);
      end else begin
        check("scan_addr", 32'(host.scan_addr), 32'(scan_q[0].addr));
        check("scan_data", host.scan_data, scan_q[0].data);
        check("scan_last", 32'(host.scan_last), 32'(scan_q[0].last));
        if (host.scan_ready) void'(scan_q.pop_front());
      end
    end
  end

  // Command-error monitor: each pulse must land on the cycle the scoreboard predicts.
  always @(negedge clk) begin
    if (host.cmd_err === 1'b1) begin
      if (err_q.size() == 0) check("cmd_err_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else check("cmd_err_cycle", 32'(cyc), 32'(err_q.pop_front()));
    end
  end

  always @(negedge clk) if (cpu_en === 1'b1) en_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cpu_pc = '0;
    cpu_retire = 1'b0;
    host.cmd_valid = 1'b0;
    host.cmd_op = OP_NOP;
    host.cmd_idx = '0;
    host.cmd_arg = '0;
    host.scan_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_debug_addr", 32'(debug_addr), 32'd0);
    check("rst_scan_valid", 32'(host.scan_valid), 32'd0);
    check("rst_debug_en", 32'(debug_en), 32'd0);
    check("rst_cmd_ready", 32'(host.cmd_ready), 32'd1);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    check("rst_step_err", 32'(step_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Breakpoint at 0x10 stops RUN after the third retire
    send_cmd(OP_SET, 3'd0, 32'h10, 1'b0);
    send_cmd(OP_RUN, 3'd0, 32'h0, 1'b0);
    check("run_cpu_en", 32'(cpu_en), 32'd1);
    retire(32'h4);
    check("run_pc4_halted", 32'(halted), 32'd0);
    retire(32'h8);
    check("run_pc8_halted", 32'(halted), 32'd0);
    retire(32'h10);
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_cpu_en", 32'(cpu_en), 32'd0);
    check("bp_hit0", 32'(bp_hit), 32'h1);

    // HALT command and breakpoint match in the same cycle
    send_cmd(OP_SET, 3'd1, 32'h20, 1'b0);
    send_cmd(OP_RUN, 3'd0, 32'h0, 1'b0);
    check("run2_bp_cleared", 32'(bp_hit), 32'h0);
    host.cmd_valid = 1'b1;
    host.cmd_op = OP_HALT;
    retire(32'h20);
    host.cmd_valid = 1'b0;
    host.cmd_op = OP_NOP;
    check("dual_halted", 32'(halted), 32'd1);
    check("dual_bp_hit1", 32'(bp_hit), 32'h2);
    tick();
    check("dual_still_halted", 32'(halted), 32'd1);

    // Illegal SCAN during RUN: error pulse, Cpu keeps running
    send_cmd(OP_RUN, 3'd0, 32'h0, 1'b0);
    send_cmd(OP_SCAN, 3'd0, 32'h0, 1'b1);
    tick();
    check("run_scan_cpu_en", 32'(cpu_en), 32'd1);
    check("run_scan_debug_en", 32'(debug_en), 32'd0);
    send_cmd(OP_HALT, 3'd0, 32'h0, 1'b0);
    check("halt_cmd_halted", 32'(halted), 32'd1);

    // Out-of-range breakpoint index and reserved opcode
    send_cmd(OP_SET, 3'd5, 32'h40, 1'b1);
    send_cmd(OP_RSVD, 3'd0, 32'h0, 1'b1);
    tick();
    check("rsvd_halted", 32'(halted), 32'd1);

    // CLR_BP disables the entry
    send_cmd(OP_CLR, 3'd0, 32'h0, 1'b0);
    send_cmd(OP_RUN, 3'd0, 32'h0, 1'b0);
    retire(32'h10);
    check("clr_no_halt", 32'(halted), 32'd0);
    send_cmd(OP_HALT, 3'd0, 32'h0, 1'b0);

    // STEP with a retire in its fifth cycle; breakpoint on that PC is ignored
    send_cmd(OP_SET, 3'd0, 32'h10, 1'b0);
    en_cnt = 0;
    send_cmd(OP_STEP, 3'd0, 32'h0, 1'b0);
    repeat (4) tick();
    retire(32'h10);
    tick();
    check("step_en_cycles", 32'(en_cnt), 32'd5);
    check("step_halted", 32'(halted), 32'd1);
    check("step_bp_ignored", 32'(bp_hit), 32'h0);
    check("step_no_err", 32'(step_err), 32'd0);

    // STEP without a retire times out after 64 cycles
    en_cnt = 0;
    send_cmd(OP_STEP, 3'd0, 32'h0, 1'b0);
    wait_halted("tmo_halted", 200);
    check("tmo_en_cycles", 32'(en_cnt), 32'd64);
    check("tmo_step_err", 32'(step_err), 32'd1);
    send_cmd(OP_RUN, 3'd0, 32'h0, 1'b0);
    check("run_clears_step_err", 32'(step_err), 32'd0);
    send_cmd(OP_HALT, 3'd0, 32'h0, 1'b0);

    // Full-rate scan of addresses 0..3
    host.scan_ready = 1'b1;
    push_scan();
    send_cmd(OP_SCAN, 3'd0, 32'h0, 1'b0);
    t0 = cyc;
    check("scan_debug_en", 32'(debug_en), 32'd1);
    check("scan_cpu_en", 32'(cpu_en), 32'd0);
    check("scan_cmd_ready", 32'(host.cmd_ready), 32'd0);
    wait_halted("scan_done", 100);
    check("scan_duration", 32'(cyc - t0), 32'd12);
    check("scan_queue_empty", 32'(scan_q.size()), 32'd0);
    check("scan_wrap_addr", 32'(debug_addr), 32'd0);
    check("scan_debug_en_off", 32'(debug_en), 32'd0);

    // Back-pressure: beat 1 held for 10 cycles
    push_scan();
    send_cmd(OP_SCAN, 3'd0, 32'h0, 1'b0);
    for (int n = 0; n < 50 && !(host.scan_valid && host.scan_addr == 7'd1); n++) tick();
    host.scan_ready = 1'b0;
    repeat (10) tick();
    host.scan_ready = 1'b1;
    wait_halted("bp_scan_done", 100);
    check("bp_scan_queue_empty", 32'(scan_q.size()), 32'd0);

    // Reset in the middle of a scan drops the pending beat
    host.scan_ready = 1'b0;
    begin
      beat_t b;
      b.addr = '0;
      b.data = '0;
      b.last = 1'b0;
      scan_q.push_back(b);
    end
    send_cmd(OP_SCAN, 3'd0, 32'h0, 1'b0);
    for (int n = 0; n < 20 && !host.scan_valid; n++) tick();
    check("mid_scan_valid", 32'(host.scan_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_scan_valid", 32'(host.scan_valid), 32'd0);
    check("abort_halted", 32'(halted), 32'd1);
    check("abort_debug_en", 32'(debug_en), 32'd0);
    scan_q.delete();
    rst_n = 1'b1;
    host.scan_ready = 1'b1;
    repeat (5) tick();
    check("abort_no_beat", 32'(host.scan_valid), 32'd0);
    check("err_queue_empty", 32'(err_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
